alu_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_core.sv | 27 ++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encoding shared by the ALU arbiter and its core
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SLT = 4'b1010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b0111;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU; a, b, op in; result and zero (result == 0) out
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   op,
    output logic [W-1:0] result,
    output logic         zero
);
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLT:  result = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            default: result = '0;
        endcase
    end
    assign zero = result == '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between two valid/ready requesters; one op in flight, tagged response, op counter
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [W-1:0]     resp_result,
    output logic             resp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [3:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic             id_q, id_d, zero_q, zero_d, vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     alu_res;
    logic             alu_zero, gnt, take;

    alu_core #(.W(W)) u_core (.a(a_q), .b(b_q), .op(op_q), .result(alu_res), .zero(alu_zero));

    // prio_q names the requester that wins a tie; a lone requester wins regardless
    always_comb begin
        gnt     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        take    = state_q == ST_IDLE && (req0_valid || req1_valid);
        state_d = state_q;
        prio_d  = prio_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        res_d   = res_q;
        zero_d  = zero_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (take) begin
                state_d = ST_EXEC;
                op_d    = gnt ? req1_op : req0_op;
                a_d     = gnt ? req1_a : req0_a;
                b_d     = gnt ? req1_b : req0_b;
                id_d    = gnt;
                prio_d  = ~gnt;
            end
            ST_EXEC: begin
                res_d   = alu_res;
                zero_d  = alu_zero;
                vld_d   = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: if (resp_ready) begin
                vld_d   = 1'b0;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req0_ready  = take && !gnt;
    assign req1_ready  = take && gnt;
    assign busy        = state_q != ST_IDLE;
    assign resp_valid  = vld_q;
    assign resp_id     = id_q;
    assign resp_result = res_q;
    assign resp_zero   = zero_q;
    assign op_count    = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter against a spec-level model
module tb_alu_arbiter;
    logic        clk = 0, rst = 1;
    logic        req0_valid = 0, req1_valid = 0, resp_ready = 1;
    logic        req0_ready, req1_ready, resp_valid, resp_id, resp_zero, busy;
    logic [3:0]  req0_op = 0, req1_op = 0, op_count;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, resp_result;
    int checks = 0, fails = 0;
    int prio_m = 0, cnt_m = 0;

    alu_arbiter #(.W(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
        .resp_zero(resp_zero), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0010: return a - b;
            4'b1010: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return a ^ b;
            4'b0111: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1; req0_valid = 0; req1_valid = 0; resp_ready = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        prio_m = 0; cnt_m = 0;
    endtask

    // Drives one request pattern, holds valids through the operation, returns what was observed
    task automatic transact(input logic v0, input logic v1, input logic [3:0] o0, input logic [3:0] o1,
                            input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] a1, input logic [31:0] b1,
                            output int g, output int lat, output logic id, output logic [31:0] r,
                            output logic z, output bit leak);
        @(negedge clk);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        #1;
        g = (req0_ready && req1_ready) ? 2 : req0_ready ? 0 : req1_ready ? 1 : -1;
        leak = 0;
        @(negedge clk);
        #1;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            leak |= req0_ready | req1_ready;
            @(negedge clk);
            #1;
            lat++;
        end
        leak |= req0_ready | req1_ready;
        id = resp_id; r = resp_result; z = resp_zero;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({resp_valid, resp_id, resp_zero, busy, req0_ready, req1_ready} !== 6'd0) begin
            fails++; $display("FAIL reset_flags: got %b want 000000", {resp_valid, resp_id, resp_zero, busy, req0_ready, req1_ready});
        end
        checks++;
        if (resp_result !== 32'd0 || op_count !== 4'd0) begin
            fails++; $display("FAIL reset_values: result %0h count %0d want 0 0", resp_result, op_count);
        end
    endtask

    task automatic test_add();
        int g, lat; logic id, z; logic [31:0] r; bit leak;
        transact(1, 0, 4'b0000, 4'b0000, 5, 7, 0, 0, g, lat, id, r, z, leak);
        checks++; if (g != 0) begin fails++; $display("FAIL add_grant: got %0d want 0", g); end
        checks++; if (lat != 2) begin fails++; $display("FAIL add_latency: got %0d want 2", lat); end
        checks++; if (id !== 1'b0) begin fails++; $display("FAIL add_id: got %b want 0", id); end
        checks++; if (r !== 32'd12) begin fails++; $display("FAIL add_result: got %0d want 12", r); end
        checks++; if (z !== 1'b0) begin fails++; $display("FAIL add_zero: got %b want 0", z); end
        checks++; if (leak) begin fails++; $display("FAIL add_ready_busy: got 1 want 0"); end
        checks++; if (op_count !== 4'd1) begin fails++; $display("FAIL add_count: got %0d want 1", op_count); end
        prio_m = 1; cnt_m = 1;
    endtask

    task automatic test_alternate();
        int g, lat, eg; logic id, z; logic [31:0] r, er, a0, b0, a1, b1; logic [3:0] o0, o1; bit leak;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            o0 = 4'b0000; o1 = 4'b0110;
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            transact(1, 1, o0, o1, a0, b0, a1, b1, g, lat, id, r, z, leak);
            eg = prio_m;
            er = eg == 0 ? alu_ref(o0, a0, b0) : alu_ref(o1, a1, b1);
            prio_m = 1 - eg; cnt_m = (cnt_m + 1) % 16;
            checks++; if (g != eg) begin fails++; $display("FAIL alt_grant[%0d]: got %0d want %0d", i, g, eg); end
            checks++; if (id !== eg[0] || r !== er || lat != 2) begin
                fails++; $display("FAIL alt_resp[%0d]: id %b result %0h lat %0d want %0d %0h 2", i, id, r, lat, eg, er);
            end
            checks++; if (leak) begin fails++; $display("FAIL alt_ready_busy[%0d]: got 1 want 0", i); end
        end
        checks++; if (op_count !== 4'(cnt_m)) begin fails++; $display("FAIL alt_count: got %0d want %0d", op_count, cnt_m); end
    endtask

    task automatic test_corners();
        logic [3:0]  ops[4] = '{4'b1010, 4'b0010, 4'b0111, 4'b1111};
        logic [31:0] as[4]  = '{32'h8000_0000, 32'd3, 32'd0, 32'h1234_5678};
        logic [31:0] bs[4]  = '{32'h7FFF_FFFF, 32'd3, 32'd0, 32'h0F0F_0F0F};
        logic [31:0] rs[4]  = '{32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic        zs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        int g, lat; logic id, z; logic [31:0] r; bit leak;
        for (int i = 0; i < 4; i++) begin
            transact(0, 1, 4'b0000, ops[i], 0, 0, as[i], bs[i], g, lat, id, r, z, leak);
            prio_m = 0; cnt_m = (cnt_m + 1) % 16;
            checks++; if (g != 1 || id !== 1'b1) begin fails++; $display("FAIL corner_grant[%0d]: grant %0d id %b want 1 1", i, g, id); end
            checks++; if (r !== rs[i] || z !== zs[i]) begin
                fails++; $display("FAIL corner_result[%0d]: got %0h/%b want %0h/%b", i, r, z, rs[i], zs[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, er; logic ok; int lat; int c0;
        a = $urandom; b = $urandom; er = alu_ref(4'b0110, a, b); c0 = cnt_m;
        resp_ready = 0;
        @(negedge clk);
        req0_valid = 1; req0_op = 4'b0110; req0_a = a; req0_b = b;
        req1_valid = 1; req1_op = 4'b0000;
        #1;
        checks++; if (!(prio_m == 0 ? req0_ready : req1_ready)) begin fails++; $display("FAIL bp_accept: ready0 %b ready1 %b", req0_ready, req1_ready); end
        if (prio_m == 1) er = alu_ref(4'b0000, req1_a, req1_b);
        prio_m = 1 - prio_m;
        lat = 0;
        do begin @(negedge clk); #1; lat++; end while (!resp_valid && lat < 8);
        checks++; if (lat != 2) begin fails++; $display("FAIL bp_latency: got %0d want 2", lat); end
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (!resp_valid || resp_result !== er || req0_ready || req1_ready || !busy) ok = 0;
        end
        checks++; if (!ok) begin fails++; $display("FAIL bp_stable: got result %0h valid %b want %0h 1", resp_result, resp_valid, er); end
        checks++; if (op_count !== 4'(c0)) begin fails++; $display("FAIL bp_count_hold: got %0d want %0d", op_count, c0); end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; resp_ready = 1;
        #1;
        checks++; if (!resp_valid) begin fails++; $display("FAIL bp_valid_at_release: got 0 want 1"); end
        @(negedge clk); #1;
        cnt_m = (c0 + 1) % 16;
        checks++; if (resp_valid || busy || op_count !== 4'(cnt_m)) begin
            fails++; $display("FAIL bp_handshake: valid %b busy %b count %0d want 0 0 %0d", resp_valid, busy, op_count, cnt_m);
        end
        @(negedge clk); #1;
        checks++; if (op_count !== 4'(cnt_m)) begin fails++; $display("FAIL bp_single: got %0d want %0d", op_count, cnt_m); end
    endtask

    task automatic test_random();
        logic [3:0]  opl[9] = '{4'b0000, 4'b0010, 4'b1010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1111, 4'b0001};
        int g, lat, eg, bad; logic id, z, v0, v1; logic [31:0] r, er, a0, b0, a1, b1; logic [3:0] o0, o1; bit leak;
        logic [1:0] vv;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            vv = 2'($urandom_range(1, 3)); v0 = vv[0]; v1 = vv[1];
            o0 = opl[$urandom_range(0, 8)]; o1 = opl[$urandom_range(0, 8)];
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            transact(v0, v1, o0, o1, a0, b0, a1, b1, g, lat, id, r, z, leak);
            eg = (v0 && v1) ? prio_m : (v0 ? 0 : 1);
            er = eg == 0 ? alu_ref(o0, a0, b0) : alu_ref(o1, a1, b1);
            prio_m = 1 - eg; cnt_m = (cnt_m + 1) % 16;
            checks++;
            if (g != eg || id !== eg[0] || r !== er || z !== (er == 0) || lat != 2 || leak || op_count !== 4'(cnt_m)) begin
                fails++; bad++;
                if (bad < 5) $display("FAIL rand[%0d]: grant %0d id %b res %0h z %b lat %0d cnt %0d want %0d %0h %b 2 %0d",
                                      i, g, id, r, z, lat, op_count, eg, er, er == 0, cnt_m);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g, lat; logic id, z; logic [31:0] r; bit leak, seen;
        @(negedge clk);
        req0_valid = 1; req0_op = 4'b0000; req0_a = 1; req0_b = 2;
        #1;
        checks++; if (!req0_ready) begin fails++; $display("FAIL mid_accept: got 0 want 1"); end
        @(negedge clk);
        req0_valid = 0; rst = 1;
        #1;
        checks++; if (!busy) begin fails++; $display("FAIL mid_exec_busy: got 0 want 1"); end
        @(negedge clk);
        rst = 0;
        #1;
        prio_m = 0; cnt_m = 0;
        checks++; if (busy || op_count !== 4'd0 || resp_valid) begin
            fails++; $display("FAIL mid_after_reset: busy %b count %0d valid %b want 0 0 0", busy, op_count, resp_valid);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); #1; seen |= resp_valid; end
        checks++; if (seen) begin fails++; $display("FAIL mid_no_resp: got resp_valid 1 want 0"); end
        transact(1, 1, 4'b0101, 4'b0100, 32'hF0, 32'h0F, 32'hF0, 32'h0F, g, lat, id, r, z, leak);
        prio_m = 1; cnt_m = 1;
        checks++; if (g != 0 || r !== 32'hFF) begin fails++; $display("FAIL mid_next_grant: grant %0d result %0h want 0 ff", g, r); end
    endtask

    task automatic test_wrap();
        int g, lat; logic id, z; logic [31:0] r; bit leak;
        do_reset();
        for (int i = 0; i < 15; i++) transact(1, 0, 4'b0000, 4'b0000, $urandom, $urandom, 0, 0, g, lat, id, r, z, leak);
        checks++; if (op_count !== 4'd15) begin fails++; $display("FAIL wrap_15: got %0d want 15", op_count); end
        transact(0, 1, 4'b0000, 4'b0000, 0, 0, 9, 9, g, lat, id, r, z, leak);
        checks++; if (op_count !== 4'd0) begin fails++; $display("FAIL wrap_16: got %0d want 0", op_count); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alternate();
        test_corners();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
